code_checker_multi: RTL and testbench

- Clocked, parametrised successor to the lock's 2-bit/4-symbol code checker.
- Holds an enrolled password of up to MAX_LEN symbols, each SYM_W bits wide, and collects user entry symbols from the keypad controller.
- On commit, compares the entry against the password in length and every symbol, and emits a one-cycle unlock or fail pulse.
- Adds consecutive-fail counting, timed lockout, and re-enrollment that is permitted only while unlocked.

---
 rtl/code_checker_multi.sv | 258 +++++++++++++++++++++++++
 tb/tb_code_checker_multi.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/code_checker_multi.sv
// code_checker_multi
//   Clocked, parametrised code checker for the lock. Collects keypad symbols
//   into an entry buffer, compares them against an enrolled password on
//   commit, and emits a one-cycle unlock or fail pulse. It counts consecutive
//   failures, enforces a timed lockout, and allows re-enrollment only while
//   the lock is unlocked (or before any password has been enrolled).
//
//   Handshake: sym_valid, commit, clear and enroll_req are single-cycle
//   strobes sampled on the rising clock edge. There is no back-pressure.
//   When several strobes arrive in one cycle, clear wins over commit, and
//   commit wins over sym_valid. The losing strobes are dropped.
//
// Ports
//   clk          system clock (rising edge)
//   resetn       synchronous, active-low reset
//   sym_in       keypad symbol, qualified by sym_valid
//   sym_valid    symbol strobe
//   commit       ends the current entry or enrollment
//   clear        discards the current entry and drops unlocked
//   enroll_req   request to enter enrollment
//   unlock_pulse one-cycle pulse on a successful compare
//   fail_pulse   one-cycle pulse on a failed compare
//   unlocked     level, set by a successful compare
//   enrolled     a valid password is stored
//   locked_out   high while in LOCKOUT
//   enrolling    high while in ENROLL
//   fail_count   consecutive failed compares
//   entry_len    symbols held in the active buffer
module code_checker_multi #(
    parameter int SYM_W       = 2,
    parameter int MAX_LEN     = 8,
    parameter int MAX_FAILS   = 3,
    parameter int LOCKOUT_CYC = 1024,
    localparam int LEN_W = $clog2(MAX_LEN + 1),
    localparam int FC_W  = $clog2(MAX_FAILS + 1),
    localparam int LC_W  = $clog2(LOCKOUT_CYC + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             sym_valid,
    input  logic             commit,
    input  logic             clear,
    input  logic             enroll_req,
    output logic             unlock_pulse,
    output logic             fail_pulse,
    output logic             unlocked,
    output logic             enrolled,
    output logic             locked_out,
    output logic             enrolling,
    output logic [FC_W-1:0]  fail_count,
    output logic [LEN_W-1:0] entry_len
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        ENROLL  = 3'd2,
        COMPARE = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [SYM_W-1:0] pw_q    [MAX_LEN];
    logic [SYM_W-1:0] pw_d    [MAX_LEN];
    logic [SYM_W-1:0] entry_q [MAX_LEN];
    logic [SYM_W-1:0] entry_d [MAX_LEN];
    logic [LEN_W-1:0] pw_len_q, pw_len_d;
    logic [LEN_W-1:0] entry_len_q, entry_len_d;
    logic             ovf_q, ovf_d;
    logic             unlocked_q, unlocked_d;
    logic             enrolled_q, enrolled_d;
    logic [FC_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic [LC_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic             unlock_pulse_q, unlock_pulse_d;
    logic             fail_pulse_q, fail_pulse_d;

    logic             do_push;
    logic             do_flush;
    logic             match;
    logic [FC_W-1:0]  fail_inc;

    assign fail_inc = fail_cnt_q + FC_W'(1);

    // Only the first pw_len_q symbols take part in the compare. A length
    // mismatch or an overflowed entry fails regardless of the content.
    always_comb begin
        match = enrolled_q & ~ovf_q & (entry_len_q == pw_len_q);
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < pw_len_q) && (entry_q[i] != pw_q[i])) begin
                match = 1'b0;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        pw_d           = pw_q;
        pw_len_d       = pw_len_q;
        entry_d        = entry_q;
        entry_len_d    = entry_len_q;
        ovf_d          = ovf_q;
        unlocked_d     = unlocked_q;
        enrolled_d     = enrolled_q;
        fail_cnt_d     = fail_cnt_q;
        lock_cnt_d     = lock_cnt_q;
        unlock_pulse_d = 1'b0;
        fail_pulse_d   = 1'b0;
        do_push        = 1'b0;
        do_flush       = 1'b0;

        case (state_q)
            IDLE: begin
                if (clear) begin
                    do_flush   = 1'b1;
                    unlocked_d = 1'b0;
                end else if (commit) begin
                    state_d = COMPARE;
                end else if (sym_valid) begin
                    do_push    = 1'b1;
                    unlocked_d = 1'b0;
                    state_d    = ENTRY;
                end else if (enroll_req && (!enrolled_q || unlocked_q)) begin
                    do_flush = 1'b1;
                    state_d  = ENROLL;
                end
            end
            ENTRY: begin
                if (clear) begin
                    do_flush   = 1'b1;
                    unlocked_d = 1'b0;
                    state_d    = IDLE;
                end else if (commit) begin
                    state_d = COMPARE;
                end else if (sym_valid) begin
                    do_push    = 1'b1;
                    unlocked_d = 1'b0;
                end
            end
            ENROLL: begin
                // The entry buffer stages the new password so that an
                // aborted or invalid enrollment leaves the old one intact.
                if (clear) begin
                    do_flush   = 1'b1;
                    unlocked_d = 1'b0;
                    state_d    = IDLE;
                end else if (commit) begin
                    if ((entry_len_q != '0) && !ovf_q) begin
                        pw_d       = entry_q;
                        pw_len_d   = entry_len_q;
                        enrolled_d = 1'b1;
                    end
                    do_flush   = 1'b1;
                    unlocked_d = 1'b0;
                    state_d    = IDLE;
                end else if (sym_valid) begin
                    do_push = 1'b1;
                end
            end
            COMPARE: begin
                do_flush = 1'b1;
                state_d  = IDLE;
                if (match) begin
                    unlock_pulse_d = 1'b1;
                    unlocked_d     = 1'b1;
                    fail_cnt_d     = '0;
                end else begin
                    fail_pulse_d = 1'b1;
                    // Failures without a password are not counted, so they
                    // can never lead to lockout.
                    if (enrolled_q) begin
                        fail_cnt_d = fail_inc;
                        if (fail_inc >= FC_W'(MAX_FAILS)) begin
                            lock_cnt_d = LC_W'(LOCKOUT_CYC);
                            state_d    = LOCKOUT;
                        end
                    end
                end
            end
            LOCKOUT: begin
                // The counter is loaded on entry, so leaving at a count of 1
                // gives exactly LOCKOUT_CYC cycles in this state.
                if (lock_cnt_q == LC_W'(1)) begin
                    lock_cnt_d = '0;
                    fail_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q - LC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_flush) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                entry_d[i] = '0;
            end
            entry_len_d = '0;
            ovf_d       = 1'b0;
        end else if (do_push) begin
            // A full buffer keeps its length and remembers the overflow.
            if (entry_len_q == LEN_W'(MAX_LEN)) begin
                ovf_d = 1'b1;
            end else begin
                for (int i = 0; i < MAX_LEN; i++) begin
                    if (LEN_W'(i) == entry_len_q) begin
                        entry_d[i] = sym_in;
                    end
                end
                entry_len_d = entry_len_q + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= IDLE;
            for (int i = 0; i < MAX_LEN; i++) begin
                pw_q[i]    <= '0;
                entry_q[i] <= '0;
            end
            pw_len_q       <= '0;
            entry_len_q    <= '0;
            ovf_q          <= 1'b0;
            unlocked_q     <= 1'b0;
            enrolled_q     <= 1'b0;
            fail_cnt_q     <= '0;
            lock_cnt_q     <= '0;
            unlock_pulse_q <= 1'b0;
            fail_pulse_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            pw_q           <= pw_d;
            entry_q        <= entry_d;
            pw_len_q       <= pw_len_d;
            entry_len_q    <= entry_len_d;
            ovf_q          <= ovf_d;
            unlocked_q     <= unlocked_d;
            enrolled_q     <= enrolled_d;
            fail_cnt_q     <= fail_cnt_d;
            lock_cnt_q     <= lock_cnt_d;
            unlock_pulse_q <= unlock_pulse_d;
            fail_pulse_q   <= fail_pulse_d;
        end
    end

    assign unlock_pulse = unlock_pulse_q;
    assign fail_pulse   = fail_pulse_q;
    assign unlocked     = unlocked_q;
    assign enrolled     = enrolled_q;
    assign locked_out   = (state_q == LOCKOUT);
    assign enrolling    = (state_q == ENROLL);
    assign fail_count   = fail_cnt_q;
    assign entry_len    = entry_len_q;

endmodule

// File: tb/tb_code_checker_multi.sv
// Directed testbench for code_checker_multi with SYM_W=2, MAX_LEN=4,
// MAX_FAILS=3 and LOCKOUT_CYC=16. Inputs change 1 ns after a rising edge,
// and outputs are sampled at that same point.
module tb_code_checker_multi;

  localparam int SYM_W       = 2;
  localparam int MAX_LEN     = 4;
  localparam int MAX_FAILS   = 3;
  localparam int LOCKOUT_CYC = 16;

  logic             clk;
  logic             resetn;
  logic [SYM_W-1:0] sym_in;
  logic             sym_valid;
  logic             commit;
  logic             clear;
  logic             enroll_req;
  logic             unlock_pulse;
  logic             fail_pulse;
  logic             unlocked;
  logic             enrolled;
  logic             locked_out;
  logic             enrolling;
  logic [1:0]       fail_count;
  logic [2:0]       entry_len;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [10:0] all_outs;
  assign all_outs = {unlock_pulse, fail_pulse, unlocked, enrolled, locked_out,
                     enrolling, fail_count, entry_len};

  code_checker_multi #(
    .SYM_W      (SYM_W),
    .MAX_LEN    (MAX_LEN),
    .MAX_FAILS  (MAX_FAILS),
    .LOCKOUT_CYC(LOCKOUT_CYC)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .sym_in      (sym_in),
    .sym_valid   (sym_valid),
    .commit      (commit),
    .clear       (clear),
    .enroll_req  (enroll_req),
    .unlock_pulse(unlock_pulse),
    .fail_pulse  (fail_pulse),
    .unlocked    (unlocked),
    .enrolled    (enrolled),
    .locked_out  (locked_out),
    .enrolling   (enrolling),
    .fail_count  (fail_count),
    .entry_len   (entry_len)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] s);
    sym_in    = s;
    sym_valid = 1'b1;
    step();
    sym_valid = 1'b0;
  endtask

  task automatic enter(input int n, input logic [1:0] s0, input logic [1:0] s1,
                       input logic [1:0] s2, input logic [1:0] s3, input logic [1:0] s4);
    logic [1:0] s [5];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3; s[4] = s4;
    for (int i = 0; i < n; i++) press(s[i]);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Commit, then check: no pulse during COMPARE, the right pulse one cycle
  // later, entry flushed, and the pulse gone the cycle after.
  task automatic commit_expect(input string tag, input bit exp_unlock,
                               input bit with_sym, input logic [1:0] s);
    commit    = 1'b1;
    sym_valid = with_sym;
    sym_in    = s;
    step();
    commit    = 1'b0;
    sym_valid = 1'b0;
    check({tag, "/compare_no_pulse"}, {unlock_pulse, fail_pulse}, 0);
    step();
    check({tag, "/pulse"}, {unlock_pulse, fail_pulse}, exp_unlock ? 2'b10 : 2'b01);
    check({tag, "/entry_len"}, entry_len, 0);
    step();
    check({tag, "/pulse_one_cycle"}, {unlock_pulse, fail_pulse}, 0);
  endtask

  task automatic enroll(input string tag, input int n, input logic [1:0] s0,
                        input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] s3);
    enroll_req = 1'b1;
    step();
    enroll_req = 1'b0;
    check({tag, "/enrolling"}, enrolling, 1);
    enter(n, s0, s1, s2, s3, 2'd0);
    check({tag, "/enroll_len"}, entry_len, n);
    commit = 1'b1;
    step();
    commit = 1'b0;
    check({tag, "/enrolled"}, enrolled, 1);
    check({tag, "/enroll_done"}, {enrolling, unlocked}, 0);
  endtask

  initial begin
    resetn = 1'b0; sym_in = '0; sym_valid = 1'b0; commit = 1'b0;
    clear = 1'b0; enroll_req = 1'b0;

    // 1. reset, then commit with nothing enrolled
    step(); step();
    check("reset_outs", all_outs, 0);
    resetn = 1'b1;
    commit_expect("s1_empty", 1'b0, 1'b0, 2'd0);
    check("s1_fail_count", fail_count, 0);
    check("s1_enrolled", enrolled, 0);

    // 2. enroll 3,1,2,0 and unlock with it
    enroll("s2_enroll", 4, 2'd3, 2'd1, 2'd2, 2'd0);
    enter(4, 2'd3, 2'd1, 2'd2, 2'd0, 2'd0);
    check("s2_entry_len", entry_len, 4);
    commit_expect("s2_unlock", 1'b1, 1'b0, 2'd0);
    check("s2_unlocked", unlocked, 1);
    check("s2_fail_count", fail_count, 0);

    // 3. short, overflowing and wrong entries -> lockout
    press(2'd3);
    check("s3_sym_drops_unlocked", unlocked, 0);
    enter(2, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0);
    commit_expect("s3_short", 1'b0, 1'b0, 2'd0);
    check("s3_fail_count1", fail_count, 1);
    enter(5, 2'd3, 2'd1, 2'd2, 2'd0, 2'd1);
    check("s3_len_saturates", entry_len, 4);
    commit_expect("s3_overflow", 1'b0, 1'b0, 2'd0);
    check("s3_fail_count2", fail_count, 2);
    enter(4, 2'd3, 2'd1, 2'd2, 2'd1, 2'd0);
    commit_expect("s3_wrong", 1'b0, 1'b0, 2'd0);
    // Now at the second lockout cycle.
    check("s3_locked_out", locked_out, 1);
    check("s3_fail_count3", fail_count, 3);
    for (int i = 0; i < 14; i++) begin
      sym_valid  = (i < 4);
      sym_in     = (i == 0) ? 2'd3 : (i == 1) ? 2'd1 : (i == 2) ? 2'd2 : 2'd0;
      commit     = (i == 4) || (i == 8);
      enroll_req = (i == 5);
      clear      = (i == 6);
      step();
      check("s3_lockout_hold", locked_out, 1);
      check("s3_lockout_no_pulse", {unlock_pulse, fail_pulse}, 0);
    end
    sym_valid = 1'b0; commit = 1'b0; enroll_req = 1'b0; clear = 1'b0;
    step();
    check("s3_lockout_end", locked_out, 0);
    check("s3_fail_count_reset", fail_count, 0);
    check("s3_after_lockout", {unlocked, enrolling, entry_len}, 0);

    // 4. enroll_req ignored while locked; re-enroll after unlock
    enroll_req = 1'b1;
    step();
    enroll_req = 1'b0;
    check("s4_enroll_ignored", enrolling, 0);
    enter(4, 2'd3, 2'd1, 2'd2, 2'd0, 2'd0);
    commit_expect("s4_unlock", 1'b1, 1'b0, 2'd0);
    enroll("s4_reenroll", 2, 2'd2, 2'd2, 2'd0, 2'd0);
    enter(4, 2'd3, 2'd1, 2'd2, 2'd0, 2'd0);
    commit_expect("s4_old_code", 1'b0, 1'b0, 2'd0);
    check("s4_fail_count1", fail_count, 1);
    enter(2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0);
    commit_expect("s4_new_code", 1'b1, 1'b0, 2'd0);
    check("s4_fail_count0", fail_count, 0);

    // 5. clear discards entry; coincident sym_valid with commit is dropped
    enroll("s5_reenroll", 4, 2'd3, 2'd1, 2'd2, 2'd0);
    enter(2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0);
    check("s5_len_before_clear", entry_len, 2);
    do_clear();
    check("s5_after_clear", {unlock_pulse, fail_pulse, unlocked, entry_len}, 0);
    enter(4, 2'd3, 2'd1, 2'd2, 2'd0, 2'd0);
    commit_expect("s5_unlock", 1'b1, 1'b0, 2'd0);
    enter(3, 2'd3, 2'd1, 2'd2, 2'd0, 2'd0);
    commit_expect("s5_coincident", 1'b0, 1'b1, 2'd0);
    check("s5_fail_count", fail_count, 1);

    // 6. reset mid-lockout and mid-enroll
    enter(1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0);
    commit_expect("s6_fail2", 1'b0, 1'b0, 2'd0);
    enter(1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0);
    commit_expect("s6_fail3", 1'b0, 1'b0, 2'd0);
    step(); step();
    check("s6_in_lockout", locked_out, 1);
    resetn = 1'b0;
    step();
    check("s6_reset_lockout", all_outs, 0);
    resetn = 1'b1;
    enroll_req = 1'b1;
    step();
    enroll_req = 1'b0;
    check("s6_enrolling", enrolling, 1);
    press(2'd1);
    resetn = 1'b0;
    step();
    check("s6_reset_enroll", all_outs, 0);
    resetn = 1'b1;
    enter(2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0);
    commit_expect("s6_no_password", 1'b0, 1'b0, 2'd0);
    check("s6_fail_count", fail_count, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
